// File: rtl/gabor_pkg.sv
// Shared types and constants for the 5x5 Gabor window feeder.
package gabor_pkg;

  localparam int KERNEL_SIZE     = 5;
  localparam int NUM_LINES       = 4;
  localparam int PIXEL_WIDTH_DEF = 9;

  typedef logic signed [PIXEL_WIDTH_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } win_state_e;

endpackage

// File: rtl/gabor_line_buffer.sv
// One line of pixel history: single-port RAM, read-first.
// The read is combinational so the cascade can forward the old word into the
// next line in the same cycle the new word is written.
module gabor_line_buffer
  import gabor_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // write port; old contents were already presented on rdata this cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/gabor_window_5x5.sv
// Raster-to-5x5-window converter feeding the Gabor convolution stage.
// Optional macro GABOR_WIN_COORD_EN adds window-centre coordinate outputs.
//
// state  | meaning
// IDLE   | waiting for sof; pixels without sof are dropped
// PRIME  | rows 0..3, filling line buffers, no windows
// STREAM | rows 4..H-1, window per pixel with col>=4
// DONE   | last pixel of frame accepted; back to IDLE next cycle
module gabor_window_5x5
  import gabor_pkg::*;
#(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PIXEL_WIDTH = 9,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sof,
  input  logic                                pix_valid,
  input  logic signed [PIXEL_WIDTH-1:0]       pix_data,
  output logic                                win_valid,
  output logic [25*PIXEL_WIDTH-1:0]           win_data,
`ifdef GABOR_WIN_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]        win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]       win_y,
`endif
  output logic                                frame_done
);

  if (KERNEL_SIZE != gabor_pkg::KERNEL_SIZE) begin : g_bad_kernel
    $error("gabor_window_5x5 supports only KERNEL_SIZE=5");
  end

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = PIXEL_WIDTH;
  localparam int KS = 5;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(NUM_LINES);
  localparam logic [RW-1:0] ROW_FIRST = RW'(NUM_LINES);

  win_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          accept, emit, last_pix;

  logic [NUM_LINES-1:0][PW-1:0] lb_rd, lb_wd;
  logic [KS-1:0][KS-1:0][PW-1:0] win_q, win2_q;
  logic v1_q, d1_q, v2_q, d2_q;
`ifdef GABOR_WIN_COORD_EN
  logic [CW-1:0] x1_q, x2_q;
  logic [RW-1:0] y1_q, y2_q;
`endif

  // state, row and column registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // accept decision, coordinates of the accepted pixel, next state
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cur_col  = col_q;
    cur_row  = row_q;
    accept   = 1'b0;
    emit     = 1'b0;
    last_pix = 1'b0;
    if (pix_valid) begin
      if (sof) begin
        accept  = 1'b1;
        cur_col = '0;
        cur_row = '0;
      end else if (state_q == PRIME || state_q == STREAM) begin
        accept = 1'b1;
      end
    end
    if (accept) begin
      emit     = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
      last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      if (last_pix) begin
        state_d = DONE;
        col_d   = '0;
        row_d   = '0;
      end else if (row_d >= ROW_FIRST) begin
        state_d = STREAM;
      end else begin
        state_d = PRIME;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // line cascade: LB0 takes the new pixel, each deeper line takes the old word above it
  always_comb begin
    lb_wd[0] = pix_data;
    for (int k = 1; k < NUM_LINES; k++) lb_wd[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_lb
    gabor_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PW),
      .AW    (CW)
    ) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // 5x5 shift register: column 4 is newest, row 0 oldest (LB3), row 4 the live pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS - 1; c++) win_q[r][c] <= win_q[r][c+1];
      end
      for (int r = 0; r < NUM_LINES; r++) win_q[r][KS-1] <= lb_rd[NUM_LINES-1-r];
      win_q[KS-1][KS-1] <= pix_data;
    end
  end

  // two-stage output pipeline: snapshot the window, then present it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      d1_q       <= 1'b0;
      v2_q       <= 1'b0;
      d2_q       <= 1'b0;
      win2_q     <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
`ifdef GABOR_WIN_COORD_EN
      x1_q  <= '0;
      y1_q  <= '0;
      x2_q  <= '0;
      y2_q  <= '0;
      win_x <= '0;
      win_y <= '0;
`endif
    end else begin
      v1_q       <= emit;
      d1_q       <= emit && last_pix;
      v2_q       <= v1_q;
      d2_q       <= d1_q;
      win_valid  <= v2_q;
      frame_done <= v2_q && d2_q;
      if (v1_q) win2_q <= win_q;
      if (v2_q) win_data <= win2_q;
`ifdef GABOR_WIN_COORD_EN
      if (emit) begin
        x1_q <= cur_col - CW'(2);
        y1_q <= cur_row - RW'(2);
      end
      if (v1_q) begin
        x2_q <= x1_q;
        y2_q <= y1_q;
      end
      if (v2_q) begin
        win_x <= x2_q;
        win_y <= y2_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gabor_window_5x5.sv
// Directed bench for gabor_window_5x5 on an 8x6 image, pixel = 8*row+col.
module tb_gabor_window_5x5;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 9;
  localparam int CW = 3;
  localparam int RW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sof = 1'b0;
  logic                 pix_valid = 1'b0;
  logic signed [PW-1:0] pix_data = '0;
  logic                 win_valid;
  logic                 frame_done;
  logic [25*PW-1:0]     win_data;
`ifdef GABOR_WIN_COORD_EN
  logic [CW-1:0]        win_x;
  logic [RW-1:0]        win_y;
  int                   first_x, first_y, last_x, last_y;
`endif

  gabor_window_5x5 #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIXEL_WIDTH (PW),
    .KERNEL_SIZE (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
`ifdef GABOR_WIN_COORD_EN
    .win_x      (win_x),
    .win_y      (win_y),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25*PW-1:0] data;
    logic             done;
    int               cyc;
    int               x;
    int               y;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               win_cnt = 0;
  int               done_cnt = 0;
  logic [25*PW-1:0] first_data, last_data;
  logic             last_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [25*PW-1:0] exp_win(input int r, input int c);
    logic [25*PW-1:0] w;
    w = '0;
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        w[(5*rr+cc)*PW +: PW] = PW'(W*(r-4+rr) + (c-4+cc));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor: every window must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (win_valid) begin
        win_cnt++;
        if (frame_done) done_cnt++;
        if (win_cnt == 1) first_data = win_data;
        last_data = win_data;
        last_done = frame_done;
`ifdef GABOR_WIN_COORD_EN
        if (win_cnt == 1) begin
          first_x = int'(win_x);
          first_y = int'(win_y);
        end
        last_x = int'(win_x);
        last_y = int'(win_y);
`endif
        chk("window_expected", 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("win_data", 256'(win_data), 256'(e.data));
          chk("frame_done", 256'(frame_done), 256'(e.done));
          chk("latency_cycle", 256'(cyc), 256'(e.cyc));
`ifdef GABOR_WIN_COORD_EN
          chk("win_x", 256'(win_x), 256'(CW'(e.x)));
          chk("win_y", 256'(win_y), 256'(RW'(e.y)));
`endif
        end
      end else begin
        chk("frame_done_idle", 256'(frame_done), 256'(0));
      end
    end
  end

  task automatic send(input bit s, input int r, input int c, input bit emit, input bit last);
    exp_t e;
    @(negedge clk);
    sof       = s;
    pix_valid = 1'b1;
    pix_data  = PW'(W*r + c);
    if (emit) begin
      e.data = exp_win(r, c);
      e.done = last;
      e.cyc  = cyc + 3;
      e.x    = c - 2;
      e.y    = r - 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic frame(input int npix, input int gap);
    for (int i = 0; i < npix; i++) begin
      send(i == 0, i / W, i % W, (i / W >= 4) && (i % W >= 4), i == W*H - 1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic drain();
    idle(1);
    for (int k = 0; k < 30 && sb.size() > 0; k++) idle(1);
    idle(4);
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_win_valid", 256'(win_valid), 256'(0));
    chk("rst_win_data", 256'(win_data), 256'(0));
    chk("rst_frame_done", 256'(frame_done), 256'(0));
    rst_n = 1'b1;

    // pixels without sof are ignored
    for (int i = 0; i < 40; i++) send(1'b0, i / W, i % W, 1'b0, 1'b0);
    drain();
    chk("nosof_windows", 256'(win_cnt), 256'(0));

    // continuous frame
    win_cnt = 0; done_cnt = 0;
    frame(W*H, 0);
    drain();
    chk("full_win_count", 256'(win_cnt), 256'(8));
    chk("full_done_count", 256'(done_cnt), 256'(1));
    chk("first_pixel1", 256'(first_data[0 +: PW]), 256'(0));
    chk("first_pixel13", 256'(first_data[12*PW +: PW]), 256'(18));
    chk("first_pixel25", 256'(first_data[24*PW +: PW]), 256'(36));
    chk("last_pixel25", 256'(last_data[24*PW +: PW]), 256'(47));
    chk("last_frame_done", 256'(last_done), 256'(1));
`ifdef GABOR_WIN_COORD_EN
    chk("first_win_x", 256'(first_x), 256'(2));
    chk("first_win_y", 256'(first_y), 256'(2));
    chk("last_win_x", 256'(last_x), 256'(5));
    chk("last_win_y", 256'(last_y), 256'(3));
`endif

    // alternate-cycle valid
    win_cnt = 0; done_cnt = 0;
    frame(W*H, 1);
    drain();
    chk("alt_win_count", 256'(win_cnt), 256'(8));
    chk("alt_done_count", 256'(done_cnt), 256'(1));

    // abort after 20 pixels, then full frame
    win_cnt = 0; done_cnt = 0;
    frame(20, 0);
    frame(W*H, 0);
    drain();
    chk("abort_win_count", 256'(win_cnt), 256'(8));
    chk("abort_done_count", 256'(done_cnt), 256'(1));

    // back-to-back frames
    win_cnt = 0; done_cnt = 0;
    frame(W*H, 0);
    frame(W*H, 0);
    drain();
    chk("b2b_win_count", 256'(win_cnt), 256'(16));
    chk("b2b_done_count", 256'(done_cnt), 256'(2));

    // reset while a window is on the outputs
    win_cnt = 0;
    frame(40, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_win_valid", 256'(win_valid), 256'(1));
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    #1;
    chk("async_rst_win_valid", 256'(win_valid), 256'(0));
    chk("async_rst_win_data", 256'(win_data), 256'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    win_cnt = 0;
    for (int i = 0; i < 12; i++) send(1'b0, 4, i % W, 1'b0, 1'b0);
    drain();
    chk("post_reset_windows", 256'(win_cnt), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
